// File: rtl/pwm_dac_pkg.sv
// Shared constants and helpers for the multi-channel PWM DAC.
// Mode encoding is fixed so software and RTL agree on the meaning of the mode pin.
package pwm_dac_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Channel-index width, never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned channels);
    int unsigned w;
    w = 1;
    if (channels > 1) begin
      w = $clog2(channels);
    end
    return w;
  endfunction

endpackage

// File: rtl/pwm_dac_if.sv
// Duty-code write port: valid/ready handshake carrying a channel index and a code.
// The sample-generation logic is the master, the DAC is the slave.
interface pwm_dac_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CH_W  = 2
);

  logic             din_valid;
  logic             din_ready;
  logic [CH_W-1:0]  din_ch;
  logic [WIDTH-1:0] din;

  modport master (
    output din_valid,
    output din_ch,
    output din,
    input  din_ready
  );

  modport slave (
    input  din_valid,
    input  din_ch,
    input  din,
    output din_ready
  );

endinterface

// File: rtl/pwm_dac_chan.sv
// One PWM channel: shadow/active duty registers, compare against the shared counter,
// and the registered output pin.
module pwm_dac_chan #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             commit_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [WIDTH:0]   cnt_i,
  input  logic             center_i,
  output logic             dac_o
);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] active_q;
  logic [WIDTH-1:0] fold;
  logic [WIDTH:0]   thresh;
  logic             hit_d;
  logic             dac_q;

  always_comb begin
    // Center mode folds the up/down halves of the period onto one ramp.
    fold   = cnt_i[WIDTH] ? ~cnt_i[WIDTH-1:0] : cnt_i[WIDTH-1:0];
    thresh = {1'b1, {WIDTH{1'b0}}} - {1'b0, active_q};
    if (center_i) begin
      hit_d = ({1'b0, fold} >= thresh);
    end else begin
      hit_d = (cnt_i[WIDTH-1:0] < active_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
      dac_q    <= 1'b0;
    end else begin
      if (wr_en_i) begin
        shadow_q <= wr_data_i;
      end
      // A write landing on the commit edge bypasses the shadow.
      if (commit_i) begin
        active_q <= wr_en_i ? wr_data_i : shadow_q;
      end
      dac_q <= hit_d;
    end
  end

  assign dac_o = dac_q;

endmodule

// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM DAC: shared period counter, boundary commit of duty codes and mode,
// write-port decode and the period_start marker.
module pwm_dac_multi
  import pwm_dac_pkg::*;
#(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = ch_width(CHANNELS)
) (
  input  logic                dac_clk,
  input  logic                rst,
  pwm_dac_if.slave            wr,
  input  logic                mode,
  output logic                period_start,
  output logic [CHANNELS-1:0] dac_out
);

  logic [WIDTH:0]      cnt_q;
  logic [WIDTH:0]      cnt_d;
  logic                active_mode_q;
  logic                ready_q;
  logic                period_start_q;
  logic                wrap;
  logic                wr_fire;
  logic [CHANNELS-1:0] wr_en;

  always_comb begin
    if (active_mode_q == MODE_CENTER) begin
      wrap = &cnt_q;
    end else begin
      wrap = &cnt_q[WIDTH-1:0];
    end
    cnt_d = wrap ? '0 : cnt_q + (WIDTH+1)'(1);
  end

  // Out-of-range channel indices match no channel and are silently dropped.
  always_comb begin
    wr_fire = wr.din_valid & ready_q;
    wr_en   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (wr_fire && (wr.din_ch == CH_W'(i))) begin
        wr_en[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge dac_clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      active_mode_q  <= MODE_EDGE;
      ready_q        <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      ready_q        <= 1'b1;
      // Registered alongside the channel outputs so both see counter value 0 together.
      period_start_q <= (cnt_q == '0);
      if (wrap) begin
        active_mode_q <= mode;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pwm_dac_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk_i     (dac_clk),
      .rst_i     (rst),
      .commit_i  (wrap),
      .wr_en_i   (wr_en[g]),
      .wr_data_i (wr.din),
      .cnt_i     (cnt_q),
      .center_i  (active_mode_q == MODE_CENTER),
      .dac_o     (dac_out[g])
    );
  end

  assign wr.din_ready = ready_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_dac_multi.sv
// Bench for pwm_dac_multi at WIDTH=4, CHANNELS=2: period-level vector table, directed
// corner sequences and random traffic, all checked every cycle against a period model.
module tb_pwm_dac_multi;

  localparam int unsigned W   = 4;
  localparam int unsigned CH  = 2;
  localparam int unsigned CHW = 2;

  logic          dac_clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          period_start;
  logic [CH-1:0] dac_out;

  pwm_dac_if #(.WIDTH(W), .CH_W(CHW)) wr ();

  pwm_dac_multi #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .CH_W     (CHW)
  ) dut (
    .dac_clk      (dac_clk),
    .rst          (rst),
    .wr           (wr),
    .mode         (mode),
    .period_start (period_start),
    .dac_out      (dac_out)
  );

  always #5 dac_clk = ~dac_clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Period-level model: position within the output period, duties in force, and the
  // latest written code per channel. Writes seen during one period apply to the next.
  int m_pos, m_len;
  bit m_started, m_ready, m_mode_cur, m_mode_pend;
  int m_shadow[CH];
  int m_cur[CH];

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_shadow[i] = 0;
      m_cur[i]    = 0;
    end
    m_mode_cur  = 1'b0;
    m_mode_pend = 1'b0;
    m_len       = 16;
    m_pos       = 15;
    m_started   = 1'b0;
    m_ready     = 1'b0;
  endtask

  task automatic model_edge(input bit v, input int ch, input int d, input bit md);
    bit acc;
    acc     = v && m_ready;
    m_ready = 1'b1;
    m_pos++;
    if (m_pos == m_len) begin
      m_pos      = 0;
      m_started  = 1'b1;
      m_mode_cur = m_mode_pend;
      m_len      = m_mode_cur ? 32 : 16;
      for (int i = 0; i < CH; i++) m_cur[i] = m_shadow[i];
    end
    if (m_pos == m_len - 1) m_mode_pend = md;
    if (acc && ch < CH) m_shadow[ch] = d;
  endtask

  function automatic bit exp_bit(input int p, input int d, input bit md);
    if (!md) return p < d;
    return (p >= 16 - d) && (p <= 15 + d);
  endfunction

  task automatic check_model();
    logic [CH-1:0] e;
    logic          eps;
    e   = '0;
    eps = 1'b0;
    if (m_started) begin
      eps = (m_pos == 0);
      for (int i = 0; i < CH; i++) e[i] = exp_bit(m_pos, m_cur[i], m_mode_cur);
    end
    check("dac_out", 32'(dac_out), 32'(e));
    check("period_start", 32'(period_start), 32'(eps));
    check("din_ready", 32'(wr.din_ready), 32'(m_ready));
  endtask

  task automatic cycle();
    @(posedge dac_clk);
    if (!rst) model_edge(wr.din_valid, int'(wr.din_ch), int'(wr.din), mode);
    @(negedge dac_clk);
    check_model();
  endtask

  task automatic write(input int ch, input int d);
    wr.din_valid = 1'b1;
    wr.din_ch    = CHW'(ch);
    wr.din       = W'(d);
    cycle();
    wr.din_valid = 1'b0;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!period_start && n < 100);
    check("wait period_start", 32'(period_start), 32'd1);
  endtask

  // Called on a period_start cycle; returns at the next one.
  task automatic measure(output int len, output int h0, output int h1);
    len = 0; h0 = 0; h1 = 0;
    do begin
      len++;
      h0 += int'(dac_out[0]);
      h1 += int'(dac_out[1]);
      cycle();
    end while (!period_start && len < 100);
  endtask

  typedef struct {
    logic md;
    int   d0;
    int   d1;
    int   hi0;
    int   hi1;
    int   len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int len, h0, h1;
    logic [31:0] trace;

    vecs[0] = '{md: 1'b0, d0: 5,  d1: 15, hi0: 5,  hi1: 15, len: 16};
    vecs[1] = '{md: 1'b1, d0: 3,  d1: 0,  hi0: 6,  hi1: 0,  len: 32};
    vecs[2] = '{md: 1'b1, d0: 15, d1: 1,  hi0: 30, hi1: 2,  len: 32};
    vecs[3] = '{md: 1'b0, d0: 0,  d1: 15, hi0: 0,  hi1: 15, len: 16};
    vecs[4] = '{md: 1'b0, d0: 1,  d1: 8,  hi0: 1,  hi1: 8,  len: 16};
    vecs[5] = '{md: 1'b1, d0: 8,  d1: 7,  hi0: 16, hi1: 14, len: 32};

    // Reset held with a pending write request.
    rst          = 1'b1;
    mode         = 1'b0;
    wr.din_valid = 1'b1;
    wr.din_ch    = '0;
    wr.din       = 4'd7;
    model_reset();
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;
    cycle();
    check("ready after release", 32'(wr.din_ready), 32'd1);
    check("first period_start", 32'(period_start), 32'd1);
    wr.din_valid = 1'b0;

    // Period-level vector table.
    for (int k = 0; k < 6; k++) begin
      mode = vecs[k].md;
      write(0, vecs[k].d0);
      write(1, vecs[k].d1);
      wait_ps();
      measure(len, h0, h1);
      check($sformatf("vec%0d len", k), 32'(len), 32'(vecs[k].len));
      check($sformatf("vec%0d hi0", k), 32'(h0), 32'(vecs[k].hi0));
      check($sformatf("vec%0d hi1", k), 32'(h1), 32'(vecs[k].hi1));
    end

    // Center mode, ch0=3, rewritten to 0 mid-period.
    mode = 1'b1;
    write(0, 3);
    wait_ps();
    for (int p = 0; p < 32; p++) begin
      trace[p]     = dac_out[0];
      wr.din_valid = (p == 5);
      wr.din_ch    = '0;
      wr.din       = '0;
      cycle();
    end
    wr.din_valid = 1'b0;
    check("center trace", trace, 32'h0007_E000);
    check("center next ps", 32'(period_start), 32'd1);
    for (int p = 0; p < 32; p++) begin
      trace[p] = dac_out[0];
      cycle();
    end
    check("center zero trace", trace, 32'h0);

    // Update boundaries in edge mode.
    mode = 1'b0;
    wait_ps();
    wait_ps();
    for (int i = 0; i < 3; i++) cycle();
    write(1, 2);
    write(1, 9);
    wait_ps();
    measure(len, h0, h1);
    check("last write wins", 32'(h1), 32'd9);
    while (m_pos != m_len - 2) cycle();
    write(1, 4);
    wait_ps();
    measure(len, h0, h1);
    check("wrap-edge bypass", 32'(h1), 32'd4);
    check("ready for bad ch", 32'(wr.din_ready), 32'd1);
    write(3, 15);
    write(2, 15);
    wait_ps();
    measure(len, h0, h1);
    check("bad ch0", 32'(h0), 32'd0);
    check("bad ch1", 32'(h1), 32'd4);

    // Mode switch mid-period.
    len = 0;
    do begin
      if (len == 8) mode = 1'b1;
      len++;
      cycle();
    end while (!period_start && len < 100);
    check("switch cur len", 32'(len), 32'd16);
    measure(len, h0, h1);
    check("switch next len", 32'(len), 32'd32);
    mode = 1'b0;
    measure(len, h0, h1);
    check("switch back cur len", 32'(len), 32'd32);
    measure(len, h0, h1);
    check("switch back next len", 32'(len), 32'd16);

    // Asynchronous reset mid-period.
    write(0, 10);
    wait_ps();
    for (int i = 0; i < 7; i++) cycle();
    check("pre-reset ch0", 32'(dac_out[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async dac_out", 32'(dac_out), 32'd0);
    check("async period_start", 32'(period_start), 32'd0);
    check("async ready", 32'(wr.din_ready), 32'd0);
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    wait_ps();
    measure(len, h0, h1);
    check("post-reset ch0", 32'(h0), 32'd0);
    write(0, 10);
    wait_ps();
    measure(len, h0, h1);
    check("rewrite ch0", 32'(h0), 32'd10);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      wr.din_valid = 1'($urandom_range(0, 1));
      wr.din_ch    = CHW'($urandom_range(0, 3));
      wr.din       = W'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      cycle();
    end
    wr.din_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_dac_multi.md
# pwm_dac_multi

Multi-channel PWM DAC: the parametrised successor to our single-channel 12-bit PWM DAC. It drives CHANNELS independent PWM outputs from one shared period counter. Duty codes arrive over a valid/ready write port and are double-buffered, so updates take effect only at a period boundary (glitch-free). A run-time mode selects edge-aligned or center-aligned PWM. The block sits between the sample-generation logic and the external RC-filtered DAC pins.

## Interface
- WIDTH, 12, duty-code width; edge-mode period = 2^WIDTH cycles
- CHANNELS, 4, number of PWM outputs (≥1)
- CH_W, $clog2(CHANNELS) (min 1), channel-index width
- dac_clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- din_valid  input  1  duty write request
- din_ready  output  1  block can accept a write
- din_ch  input  CH_W  target channel
- din  input  WIDTH  duty code
- mode  input  1  0 = edge-aligned, 1 = center-aligned; sampled only at period boundary
- period_start  output  1  one-cycle pulse on the first cycle of every period
- dac_out  output  CHANNELS  registered PWM outputs

## Operation
- Write accepted when din_valid && din_ready. The shadow[din_ch] register gets din. If din_ch ≥ CHANNELS, the write is accepted and discarded.
- din_ready = 0 while rst is asserted; 1 from the first clock after release, then always 1.
- Counter c is WIDTH+1 bits and resets to 0.
  - Edge mode: c counts 0..2^WIDTH−1, then wraps to 0.
  - Center mode: c counts 0..2^(WIDTH+1)−1, then wraps to 0.
- Commit: on the edge where c wraps to 0, the following happen together:
  - active[i] ← shadow[i] for all channels.
  - active_mode ← mode.
  - The counter continues under the new mode.
- A write accepted on the wrap edge is bypassed into active for the new period (and also written to shadow).
- Multiple writes to one channel within a period: the last write wins.
- Edge mode output: dac_out[i] = (c[WIDTH−1:0] < active[i]). High for active[i] cycles at the start of the period.
- Center mode output:
  - v = c[WIDTH] ? ~c[WIDTH−1:0] : c[WIDTH−1:0].
  - dac_out[i] = (v ≥ 2^WIDTH − active[i]).
  - High for 2·active[i] cycles, symmetric about mid-period.
- Duty 0 means the output is never high. Max code 2^WIDTH−1 means high for all but 1 cycle (edge mode) or all but 2 cycles (center mode).
- A mode change mid-period has no effect until the next wrap.

## Timing
- dac_out and period_start are registered. They are mutually aligned: period_start is high in the same cycle as the first dac_out cycle of a period.
- Write-to-output latency: a write is visible from the first cycle of the next period (period_start cycle). A write on the wrap edge is visible in the period starting 1 cycle later.
- Reset values: c = 0, shadow = 0, active = 0, active_mode = edge, dac_out = 0, period_start = 0, din_ready = 0.
- Asserting rst mid-period forces all outputs low immediately. After release:
  - period_start pulses 1 cycle after the first counter edge (the counter restarts at 0).
  - All duties are 0 until rewritten.
- No combinational path from din_* to dac_out or period_start.

## Structure
- Package pwm_dac_pkg holds:
  - mode constants MODE_EDGE = 1'b0 and MODE_CENTER = 1'b1.
  - the function computing CH_W.
- Sub-module pwm_dac_chan: per-channel shadow/active registers, compare logic and dac_out flop. Instantiated CHANNELS times in a generate loop.
- The top level holds:
  - the shared counter
  - commit/wrap detection
  - the period_start flop
  - write-port decode

## Test plan
All scenarios use WIDTH=4, CHANNELS=2.

1. Reset: hold rst for 3 cycles with din_valid=1 → din_ready=0, dac_out=00, period_start=0 throughout. din_ready=1 one cycle after release.
2. Edge mode, write ch0=5 and ch1=15 → from the next period_start:
   - dac_out[0] is high for 5 cycles and low for 11.
   - dac_out[1] is high for 15 cycles and low for 1.
   - period_start repeats every 16 cycles.
3. Center mode, ch0=3, ch0 then rewritten to 0 mid-period:
   - Current period (32 cycles): dac_out[0] is high for cycles 13–18 of the period (6 cycles).
   - Next period: dac_out[0] is fully low.
4. Update boundaries:
   - Writes of ch1=2 and then ch1=9 mid-period → no change until the boundary, then 9 applies.
   - A write of ch1=4 on the wrap edge → 4 applies in the period starting one cycle later.
   - A write with din_ch=3 → accepted (ready=1), no output change.
5. Mode switch: toggle mode mid-period → the current period completes at 16 cycles, the next period is 32 cycles, and period_start spacing changes exactly at the boundary.
6. Async reset: assert rst at cycle 7 of a period with ch0=10 → dac_out[0] drops in the same cycle, without waiting for a clock edge. After release, output stays low until ch0 is rewritten.
